// File: rtl/regread_port_arbiter.sv
// regread_port_arbiter: shares register-file read ports among selected uops, round-robin with starvation override
module regread_port_arbiter #(
    parameter  int NUM_REQ    = 4,
    parameter  int NUM_PORTS  = 4,
    parameter  int PREG_W     = 6,
    parameter  int STARVE_LIM = 8,
    localparam int IW         = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          i_req_valid,
    input  logic [NUM_REQ-1:0]          i_req_need1,
    input  logic [NUM_REQ-1:0]          i_req_need2,
    input  logic [NUM_REQ*PREG_W-1:0]   i_req_src1,
    input  logic [NUM_REQ*PREG_W-1:0]   i_req_src2,
    output logic [NUM_REQ-1:0]          o_grant,
    output logic [NUM_REQ-1:0]          o_hold,
    output logic [NUM_PORTS-1:0]        o_port_valid,
    output logic [NUM_PORTS*PREG_W-1:0] o_port_addr,
    output logic [NUM_PORTS*IW-1:0]     o_port_owner,
    output logic [NUM_PORTS-1:0]        o_port_is_src2
);
    localparam int SW = $clog2(STARVE_LIM) + 1;

    logic [IW-1:0]               r_rr;
    logic [SW-1:0]               r_cnt [NUM_REQ];
    logic [IW-1:0]               w_rr;
    logic [IW-1:0]               w_rr_nxt;
    logic                        w_adv;
    logic [NUM_PORTS-1:0]        w_pv;
    logic [NUM_PORTS-1:0]        w_ps;
    logic [NUM_PORTS*PREG_W-1:0] w_pa;
    logic [NUM_PORTS*IW-1:0]     w_po;

    // While in reset the arbiter behaves as if the pointer were already cleared
    assign w_rr   = rst ? '0 : r_rr;
    assign o_hold = i_req_valid & ~o_grant;

    // Greedy scan: lowest starved requester first, then round-robin from the pointer
    always_comb begin
        int            used;
        logic          star_v;
        logic [IW-1:0] star;
        logic [IW-1:0] idx;
        logic [IW-1:0] last;
        logic [NUM_REQ-1:0] seen;
        logic [PREG_W-1:0]  a;
        logic [PREG_W-1:0]  b;
        logic          shared;
        logic [1:0]    cost;
        o_grant = '0;
        w_pv    = '0;
        w_ps    = '0;
        w_pa    = '0;
        w_po    = '0;
        w_adv   = 1'b0;
        used    = 0;
        star_v  = 1'b0;
        star    = '0;
        idx     = '0;
        last    = '0;
        seen    = '0;
        a       = '0;
        b       = '0;
        shared  = 1'b0;
        cost    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (!rst && r_cnt[i] == SW'(STARVE_LIM)) begin
                star_v = 1'b1;
                star   = IW'(i);
            end
        end
        for (int k = 0; k <= NUM_REQ; k++) begin
            idx = (k == 0) ? star : IW'((int'(w_rr) + k - 1) % NUM_REQ);
            if ((k != 0 || star_v) && !seen[idx]) begin
                seen[idx] = 1'b1;
                a         = i_req_src1[idx*PREG_W +: PREG_W];
                b         = i_req_src2[idx*PREG_W +: PREG_W];
                shared    = i_req_need1[idx] & i_req_need2[idx] & (a == b);
                cost      = !i_req_valid[idx] ? 2'd0 : shared ? 2'd1 :
                            {1'b0, i_req_need1[idx]} + {1'b0, i_req_need2[idx]};
                if (int'(cost) <= NUM_PORTS - used) begin
                    o_grant[idx] = 1'b1;
                    if (cost != 2'd0) begin
                        if (i_req_need1[idx]) begin
                            w_pv[used +: 1]         = 1'b1;
                            w_pa[used*PREG_W +: PREG_W] = a;
                            w_po[used*IW +: IW]     = idx;
                            used++;
                        end
                        if (i_req_need2[idx] && !shared) begin
                            w_pv[used +: 1]         = 1'b1;
                            w_ps[used +: 1]         = 1'b1;
                            w_pa[used*PREG_W +: PREG_W] = b;
                            w_po[used*IW +: IW]     = idx;
                            used++;
                        end
                        last  = idx;
                        w_adv = 1'b1;
                    end
                end
            end
        end
        w_rr_nxt = IW'((int'(last) + 1) % NUM_REQ);
    end

    // Register the port allocation, advance the pointer and track starvation
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr           <= '0;
            o_port_valid   <= '0;
            o_port_addr    <= '0;
            o_port_owner   <= '0;
            o_port_is_src2 <= '0;
            for (int i = 0; i < NUM_REQ; i++) r_cnt[i] <= '0;
        end else begin
            o_port_valid   <= w_pv;
            o_port_addr    <= w_pa;
            o_port_owner   <= w_po;
            o_port_is_src2 <= w_ps;
            if (w_adv) r_rr <= w_rr_nxt;
            for (int i = 0; i < NUM_REQ; i++)
                r_cnt[i] <= (i_req_valid[i] && !o_grant[i]) ?
                            ((r_cnt[i] == SW'(STARVE_LIM)) ? r_cnt[i] : r_cnt[i] + 1'b1) : '0;
        end
    end
endmodule
